// File: rtl/accelerator_ctrl.sv
// Sequencer for an NxN systolic-array accelerator: walks one job through
// weight/input loading, weight preload, compute, result readout and post-op drain.
module accelerator_ctrl #(
  parameter int ARRAYWIDTH = 4,
  parameter int OUT_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] act_sel,
  output logic       busy,
  output logic       done,
  output logic       data_req,
  output logic       out_valid,
  output logic       weight_buffer_load_en,
  output logic       input_buffer_load_en,
  output logic       weight_buffer_out_en,
  output logic       write_weight_en,
  output logic       input_buffer_out_en,
  output logic       output_buffer_load_en,
  output logic       output_buffer_out_en,
  output logic       relu_en,
  output logic       softmax_en
);

  localparam int CW = $clog2(3 * ARRAYWIDTH);
  localparam logic [CW-1:0] LAST_N    = CW'(ARRAYWIDTH - 1);
  localparam logic [CW-1:0] LAST_C    = CW'(3 * ARRAYWIDTH - 2);
  localparam logic [CW-1:0] LAST_IN   = CW'(2 * ARRAYWIDTH - 2);
  localparam logic [CW-1:0] FIRST_OL  = CW'(ARRAYWIDTH);
  localparam logic [CW-1:0] LAST_F    = CW'(OUT_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_IN, PRELOAD, COMPUTE, OUTPUT, FLUSH, DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    mode, mode_nx;
  logic          busy_nx, done_nx, data_req_nx;
  logic          wload_nx, iload_nx, wout_nx, wwrite_nx;
  logic          iout_nx, oload_nx, oout_nx, relu_nx, softmax_nx;
  logic          post_nx;

  // Strobes are decoded from the next state and count so every output is a flop
  // that lines up with the state it belongs to.
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD_W;
          mode_nx  = act_sel;
        end
      end
      LOAD_W:  if (cnt == LAST_N) state_nx = LOAD_IN;
      LOAD_IN: if (cnt == LAST_N) state_nx = PRELOAD;
      PRELOAD: if (cnt == LAST_N) state_nx = COMPUTE;
      COMPUTE: if (cnt == LAST_C) state_nx = OUTPUT;
      OUTPUT: begin
        if (cnt == LAST_N) begin
          if (OUT_LAT == 0) state_nx = DONE;
          else              state_nx = FLUSH;
        end
      end
      FLUSH:   if (cnt == LAST_F) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (state_nx != state || state == IDLE) cnt_nx = '0;
    else                                    cnt_nx = cnt + 1'b1;

    busy_nx     = (state_nx != IDLE);
    done_nx     = (state_nx == DONE);
    wload_nx    = (state_nx == LOAD_W);
    iload_nx    = (state_nx == LOAD_IN);
    data_req_nx = wload_nx || iload_nx;
    wout_nx     = (state_nx == PRELOAD);
    wwrite_nx   = (state_nx == PRELOAD);
    iout_nx     = (state_nx == COMPUTE) && (cnt_nx <= LAST_IN);
    oload_nx    = (state_nx == COMPUTE) && (cnt_nx >= FIRST_OL);
    oout_nx     = (state_nx == OUTPUT);
    // Post-op enables stay up through FLUSH so the post-op pipeline drains.
    post_nx     = (state_nx == OUTPUT) || (state_nx == FLUSH);
    relu_nx     = post_nx && (mode_nx == 2'b01);
    softmax_nx  = post_nx && (mode_nx == 2'b10);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      mode                  <= 2'b00;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      data_req              <= 1'b0;
      weight_buffer_load_en <= 1'b0;
      input_buffer_load_en  <= 1'b0;
      weight_buffer_out_en  <= 1'b0;
      write_weight_en       <= 1'b0;
      input_buffer_out_en   <= 1'b0;
      output_buffer_load_en <= 1'b0;
      output_buffer_out_en  <= 1'b0;
      relu_en               <= 1'b0;
      softmax_en            <= 1'b0;
    end else begin
      state                 <= state_nx;
      cnt                   <= cnt_nx;
      mode                  <= mode_nx;
      busy                  <= busy_nx;
      done                  <= done_nx;
      data_req              <= data_req_nx;
      weight_buffer_load_en <= wload_nx;
      input_buffer_load_en  <= iload_nx;
      weight_buffer_out_en  <= wout_nx;
      write_weight_en       <= wwrite_nx;
      input_buffer_out_en   <= iout_nx;
      output_buffer_load_en <= oload_nx;
      output_buffer_out_en  <= oout_nx;
      relu_en               <= relu_nx;
      softmax_en            <= softmax_nx;
    end
  end

  // out_valid tracks the output buffer read strobe through the post-op latency.
  generate
    if (OUT_LAT == 0) begin : g_no_lat
      assign out_valid = output_buffer_out_en;
    end else begin : g_lat
      logic [OUT_LAT-1:0] dly, dly_nx;

      always_comb begin
        dly_nx    = dly << 1;
        dly_nx[0] = output_buffer_out_en;
      end

      always_ff @(posedge clk) begin
        if (!rst) dly <= '0;
        else      dly <= dly_nx;
      end

      assign out_valid = dly[OUT_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_accelerator_ctrl.sv
// Self-checking bench for accelerator_ctrl: a per-job timeline scoreboard checks
// every output bit every cycle, driven from a job table plus reset/held-start sequences.
module tb_accelerator_ctrl;

  localparam int N   = 4;
  localparam int L   = 1;
  localparam int JOB = 7 * N + L;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] act_sel = 2'b00;
  logic       busy, done, data_req, out_valid;
  logic       weight_buffer_load_en, input_buffer_load_en, weight_buffer_out_en;
  logic       write_weight_en, input_buffer_out_en, output_buffer_load_en;
  logic       output_buffer_out_en, relu_en, softmax_en;
  logic [12:0] dut_vec;

  always #5 clk = ~clk;

  accelerator_ctrl #(.ARRAYWIDTH(N), .OUT_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .act_sel(act_sel),
    .busy(busy), .done(done), .data_req(data_req), .out_valid(out_valid),
    .weight_buffer_load_en(weight_buffer_load_en),
    .input_buffer_load_en(input_buffer_load_en),
    .weight_buffer_out_en(weight_buffer_out_en),
    .write_weight_en(write_weight_en),
    .input_buffer_out_en(input_buffer_out_en),
    .output_buffer_load_en(output_buffer_load_en),
    .output_buffer_out_en(output_buffer_out_en),
    .relu_en(relu_en), .softmax_en(softmax_en)
  );

  assign dut_vec = {busy, done, data_req, out_valid,
                    weight_buffer_load_en, input_buffer_load_en,
                    weight_buffer_out_en, write_weight_en,
                    input_buffer_out_en, output_buffer_load_en,
                    output_buffer_out_en, relu_en, softmax_en};

  logic [12:0] sb[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cycle = 0;
  bit  idle_prev = 1'b0;
  int  done_cycles[$];

  typedef struct {
    string      name;
    logic [1:0] sel_start;
    logic [1:0] sel_mid;
    int         spur0;
    int         spur1;
    int         exp_relu;
    int         exp_sm;
  } job_t;

  job_t jobs[5];

  // Expected output vector at offset 'off' cycles after start was accepted.
  function automatic logic [12:0] exp_vec(int off, logic [1:0] m);
    logic b, d, dr, ov, wl, il, wo, ww, io, ol, oo, post;
    b    = (off >= 1) && (off <= JOB);
    d    = (off == JOB);
    wl   = (off >= 1) && (off <= N);
    il   = (off >= N + 1) && (off <= 2 * N);
    dr   = wl || il;
    wo   = (off >= 2 * N + 1) && (off <= 3 * N);
    ww   = wo;
    io   = (off >= 3 * N + 1) && (off <= 5 * N - 1);
    ol   = (off >= 4 * N + 1) && (off <= 6 * N - 1);
    oo   = (off >= 6 * N) && (off <= 7 * N - 1);
    ov   = (off >= 6 * N + L) && (off <= 7 * N - 1 + L);
    post = (off >= 6 * N) && (off <= 7 * N - 1 + L);
    return {b, d, dr, ov, wl, il, wo, ww, io, ol, oo,
            post && (m == 2'b01), post && (m == 2'b10)};
  endfunction

  task automatic checkOutput(input string name);
    logic [12:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      idle_prev = 1'b0;
    end else begin
      e = '0;
      idle_prev = 1'b1;
    end
    compared++;
    if (dut_vec !== e) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cycle, dut_vec, e);
    end
    if (done) done_cycles.push_back(cycle);
  endtask

  // Drives one cycle of inputs, updates the job timeline at the edge, then checks.
  task automatic applyStimulus(input logic s, input logic [1:0] sel, input logic r,
                               input string name);
    @(negedge clk);
    start   = s;
    act_sel = sel;
    rst     = r;
    @(posedge clk);
    cycle++;
    if (!r) begin
      sb.delete();
    end else if (idle_prev && s) begin
      for (int off = 1; off <= JOB; off++) sb.push_back(exp_vec(off, sel));
    end
    #1;
    checkOutput(name);
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int rc, sc;
    logic s;
    logic [1:0] sel;

    jobs[0] = '{"plain",           2'b00, 2'b00, 0, 0, 0,     0};
    jobs[1] = '{"softmax_to_relu", 2'b10, 2'b01, 0, 0, 0,     N + L};
    jobs[2] = '{"relu",            2'b01, 2'b01, 0, 0, N + L, 0};
    jobs[3] = '{"act11_spurious",  2'b11, 2'b11, 3, 20, 0,    0};
    jobs[4] = '{"relu_spur_sm",    2'b01, 2'b10, 3, 20, N + L, 0};

    // Reset held with start high: outputs stay 0 and no job is queued.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'b0, "reset_hold");

    // Table jobs run back to back; each begins the cycle after the previous idle.
    for (int t = 0; t < 5; t++) begin
      applyStimulus(1'b1, jobs[t].sel_start, 1'b1, jobs[t].name);
      rc = 0;
      sc = 0;
      for (int j = 1; j < JOB + 1; j++) begin
        s   = (j == jobs[t].spur0) || (j == jobs[t].spur1);
        sel = (j >= 10) ? jobs[t].sel_mid : jobs[t].sel_start;
        applyStimulus(s, sel, 1'b1, jobs[t].name);
        rc += int'(relu_en);
        sc += int'(softmax_en);
      end
      checkCount({jobs[t].name, "_relu_cycles"}, rc, jobs[t].exp_relu);
      checkCount({jobs[t].name, "_softmax_cycles"}, sc, jobs[t].exp_sm);
    end

    // One-edge reset in COMPUTE, then a fresh job runs its full timeline.
    applyStimulus(1'b1, 2'b00, 1'b1, "rst_mid_job");
    for (int j = 1; j < 15; j++) applyStimulus(1'b0, 2'b00, 1'b1, "rst_mid_job");
    applyStimulus(1'b0, 2'b00, 1'b0, "rst_mid_pulse");
    applyStimulus(1'b1, 2'b10, 1'b1, "after_rst");
    for (int j = 1; j < JOB + 1; j++) applyStimulus(1'b0, 2'b00, 1'b1, "after_rst");

    // Start held high: jobs repeat with a fixed done-to-done period.
    done_cycles.delete();
    for (int i = 0; i < 62; i++) applyStimulus(1'b1, 2'b01, 1'b1, "held_start");
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 2'b00, 1'b1, "held_drain");
    checkCount("held_done_count", done_cycles.size(), 3);
    for (int i = 1; i < done_cycles.size(); i++)
      checkCount("held_done_period", done_cycles[i] - done_cycles[i-1], JOB + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
